vmem_map_ctl: RTL



---
 rtl/vmem_map_ctl.sv | 66 ++++++
 1 files changed

// File: rtl/vmem_map_ctl.sv
// vmem_map_ctl: sequences VMEM0/VMEM1 map lookups, microcode map writes and the power-up clear sweep
module vmem_map_ctl #(
  parameter int ADR0_WIDTH = 11,
  parameter int DATA0_WIDTH = 5,
  parameter logic [DATA0_WIDTH-1:0] INIT_VAL = 5'd31
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        lkup_req,
  input  logic [15:0]                 mapi,
  input  logic                        wr_req,
  input  logic [DATA0_WIDTH-1:0]      wr_data,
  input  logic                        init_req,
  input  logic [DATA0_WIDTH-1:0]      vmap,
  output logic                        lkup_ack,
  output logic                        vm0rp,
  output logic                        vm0wp,
  output logic [ADR0_WIDTH-1:0]       vm0_adr,
  output logic [DATA0_WIDTH-1:0]      vm0_wdata,
  output logic                        vm1rp,
  output logic [DATA0_WIDTH+4:0]      vm1_adr,
  output logic                        map_done,
  output logic                        busy
);
  typedef enum logic [2:0] {IDLE, RD0, RD1, DONE, WR, INIT} state_t;
  state_t state, state_n;
  logic [15:0] adr_q;
  logic [DATA0_WIDTH-1:0] wd_q;
  logic [ADR0_WIDTH-1:0] cnt;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      adr_q <= '0;
      wd_q <= '0;
      cnt <= '0;
    end else begin
      state <= state_n;
      if (lkup_ack) begin
        adr_q <= mapi;
        wd_q <= wr_data;
      end
      if (state == INIT) cnt <= cnt + 1'b1;
    end
  always_comb begin
    state_n = IDLE;
    unique case (state)
      IDLE: state_n = init_req ? INIT : wr_req ? WR : lkup_req ? RD0 : IDLE;
      RD0: state_n = RD1;
      RD1: state_n = DONE;
      INIT: state_n = &cnt ? IDLE : INIT;
      default: state_n = IDLE;
    endcase
  end
  // strobes decode registered state only; lkup_ack is the sole request-driven output
  always_comb begin
    lkup_ack = (state == IDLE) && !init_req && (wr_req || lkup_req);
    busy = state != IDLE;
    vm0rp = state == RD0;
    vm0wp = (state == WR) || (state == INIT);
    vm1rp = state == RD1;
    map_done = state == DONE;
    vm0_adr = (state == INIT) ? cnt : (vm0rp || state == WR) ? adr_q[15:5] : '0;
    vm0_wdata = (state == INIT) ? INIT_VAL : (state == WR) ? wd_q : '0;
    vm1_adr = vm1rp ? {vmap, adr_q[4:0]} : '0;
  end
endmodule
